alu_arbiter: RTL and testbench

Two-requester arbiter that shares the single combinational `alu` between a primary pipeline requester (port 0) and a secondary requester (port 1, e.g. an address/branch unit). It issues at most one operation per cycle into the ALU with round-robin fairness. Each result is captured into a per-requester response register with valid/ready backpressure. It sits between the requesters and the `alu` instance, drives `alu_ctrl`/`src_a`/`src_b`, and consumes `result`/`zero`.

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Each requester owns a registered response slot with
// valid/ready backpressure; a requester with an unconsumed response is not
// eligible, so a stalled requester never blocks the other one.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [CTRL_W-1:0] r0_ctrl,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_result,
    output logic              r0_zero,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [CTRL_W-1:0] r1_ctrl,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_result,
    output logic              r1_zero,

    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_src_a,
    output logic [DATA_W-1:0] alu_src_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    // 0: requester 0 won the most recent fire, 1: requester 1 did.
    logic last_grant;
    logic elig0, elig1;
    logic grant0, grant1;
    logic fire0, fire1;

    // Eligibility, round-robin grant, and the ALU operand mux.
    always_comb begin
        elig0     = r0_valid && (!r0_rvalid || r0_rready);
        elig1     = r1_valid && (!r1_rvalid || r1_rready);
        grant0    = 1'b0;
        grant1    = 1'b0;
        alu_ctrl  = '0;
        alu_src_a = '0;
        alu_src_b = '0;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
        if (grant0) begin
            alu_ctrl  = r0_ctrl;
            alu_src_a = r0_a;
            alu_src_b = r0_b;
        end else if (grant1) begin
            alu_ctrl  = r1_ctrl;
            alu_src_a = r1_a;
            alu_src_b = r1_b;
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;
    // A grant already implies valid; the AND keeps the handshake explicit.
    assign fire0    = r0_valid && grant0;
    assign fire1    = r1_valid && grant1;

    // Fairness pointer: remember who fired last; r0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (fire0) begin
            last_grant <= 1'b0;
        end else if (fire1) begin
            last_grant <= 1'b1;
        end
    end

    // Response slot 0: a new result replaces the old even when consumed same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r0_result <= '0;
            r0_zero   <= 1'b0;
        end else if (fire0) begin
            r0_rvalid <= 1'b1;
            r0_result <= alu_result;
            r0_zero   <= alu_zero;
        end else if (r0_rready) begin
            r0_rvalid <= 1'b0;
        end
    end

    // Response slot 1: same behaviour as slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_rvalid <= 1'b0;
            r1_result <= '0;
            r1_zero   <= 1'b0;
        end else if (fire1) begin
            r1_rvalid <= 1'b1;
            r1_result <= alu_result;
            r1_zero   <= alu_zero;
        end else if (r1_rready) begin
            r1_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic. A transaction
// level model decides who should be granted and pushes the expected ALU
// response into a per-requester queue; a separate monitor pops and compares
// whenever a response is handed over (rvalid && rready).
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 5;

    localparam logic [CW-1:0] ALU_ADD            = 5'd0;
    localparam logic [CW-1:0] ALU_SUB            = 5'd1;
    localparam logic [CW-1:0] ALU_AND            = 5'd2;
    localparam logic [CW-1:0] ALU_OR             = 5'd3;
    localparam logic [CW-1:0] ALU_XOR            = 5'd4;
    localparam logic [CW-1:0] ALU_COMPARE_E_ZERO = 5'd10;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] v, rr;
    logic [1:0][CW-1:0] c;
    logic [1:0][DW-1:0] a, b;

    logic r0_ready, r0_rvalid, r0_zero;
    logic r1_ready, r1_rvalid, r1_zero;
    logic [DW-1:0] r0_result, r1_result;
    logic [CW-1:0] alu_ctrl;
    logic [DW-1:0] alu_src_a, alu_src_b, alu_result;
    logic alu_zero;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural ALU: returns {zero, result}.
    function automatic logic [DW:0] alu_ref(input logic [CW-1:0] op,
                                            input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
        case (op)
            ALU_ADD:            return {1'b0, x + y};
            ALU_SUB:            return {1'b0, x - y};
            ALU_AND:            return {1'b0, x & y};
            ALU_OR:             return {1'b0, x | y};
            ALU_XOR:            return {1'b0, x ^ y};
            ALU_COMPARE_E_ZERO: return {(x == y), {DW{1'b0}}};
            default:            return '0;
        endcase
    endfunction

    assign {alu_zero, alu_result} = alu_ref(alu_ctrl, alu_src_a, alu_src_b);

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(v[0]), .r0_ready(r0_ready), .r0_ctrl(c[0]), .r0_a(a[0]), .r0_b(b[0]),
        .r0_rvalid(r0_rvalid), .r0_rready(rr[0]), .r0_result(r0_result), .r0_zero(r0_zero),
        .r1_valid(v[1]), .r1_ready(r1_ready), .r1_ctrl(c[1]), .r1_a(a[1]), .r1_b(b[1]),
        .r1_rvalid(r1_rvalid), .r1_rready(rr[1]), .r1_result(r1_result), .r1_zero(r1_zero),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Reference state: outstanding response per requester, fairness winner.
    logic [1:0] m_pend;
    logic       m_r1_last;
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];
    logic [1:0] seen_g;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Evaluate one cycle: inputs were set at the negedge; compare, update model,
    // then advance to the next negedge.
    task automatic tick();
        logic [1:0] e, g;
        #1;
        e[0] = v[0] && (!m_pend[0] || rr[0]);
        e[1] = v[1] && (!m_pend[1] || rr[1]);
        if (rst)       g = 2'b00;
        else if (&e)   g = m_r1_last ? 2'b01 : 2'b10;
        else           g = e;
        seen_g = {r1_ready, r0_ready};
        chk("r0_ready", r0_ready, g[0]);
        chk("r1_ready", r1_ready, g[1]);
        chk("r0_rvalid", r0_rvalid, m_pend[0]);
        chk("r1_rvalid", r1_rvalid, m_pend[1]);
        if (g == 2'b00) chk("alu_idle", {alu_ctrl, alu_src_a, alu_src_b}, '0);
        if (rst) begin
            m_pend = 2'b00;
            m_r1_last = 1'b1;
            q0.delete();
            q1.delete();
        end else begin
            if (g[0]) begin
                q0.push_back(alu_ref(c[0], a[0], b[0]));
                m_pend[0] = 1'b1;
                m_r1_last = 1'b0;
            end else if (rr[0]) m_pend[0] = 1'b0;
            if (g[1]) begin
                q1.push_back(alu_ref(c[1], a[1], b[1]));
                m_pend[1] = 1'b1;
                m_r1_last = 1'b1;
            end else if (rr[1]) m_pend[1] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Monitor: on every response handover, pop the expected response and compare.
    always @(negedge clk) begin
        logic [DW:0] exp;
        #2;
        if (rst !== 1'b1) begin
            if (r0_rvalid && rr[0]) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r0_resp: got %0h with no expected response", r0_result);
                end else begin
                    exp = q0.pop_front();
                    chk("r0_resp", {r0_zero, r0_result}, exp);
                end
            end
            if (r1_rvalid && rr[1]) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r1_resp: got %0h with no expected response", r1_result);
                end else begin
                    exp = q1.pop_front();
                    chk("r1_resp", {r1_zero, r1_result}, exp);
                end
            end
        end
    end

    task automatic req(input int i, input logic vv, input logic [CW-1:0] op,
                       input logic [DW-1:0] x, input logic [DW-1:0] y);
        v[i] = vv; c[i] = op; a[i] = x; b[i] = y;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; rr = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] hold;
        m_pend = 2'b00; m_r1_last = 1'b1; seen_g = '0;
        rst = 1'b1; v = '0; rr = '0; c = '0; a = '0; b = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_r0_rvalid", r0_rvalid, 1'b0);
        chk("reset_r1_rvalid", r1_rvalid, 1'b0);
        chk("reset_r0_result", r0_result, '0);
        chk("reset_r1_zero", r1_zero, 1'b0);

        // Single op.
        rr = 2'b11;
        req(0, 1'b1, ALU_ADD, 5, 7);
        tick();
        chk("single_ready", seen_g, 2'b01);
        req(0, 1'b0, ALU_ADD, 0, 0);
        chk("single_rvalid", r0_rvalid, 1'b1);
        chk("single_result", r0_result, 32'd12);
        chk("single_zero", r0_zero, 1'b0);
        tick();

        // Contention from a freshly reset fairness pointer.
        do_reset();
        rr = 2'b11;
        req(0, 1'b1, ALU_SUB, 10, 3);
        req(1, 1'b1, ALU_XOR, 32'hF0, 32'hFF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("contend_grant", seen_g, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) chk("contend_r0", r0_result, 32'd7);
            else            chk("contend_r1", r1_result, 32'h0F);
        end
        v = '0;
        tick();

        // Backpressure on r0 while r1 keeps issuing.
        rr = 2'b10;
        req(0, 1'b1, ALU_OR, 1, 2);
        tick();
        req(0, 1'b1, ALU_ADD, 4, 4);
        for (int k = 0; k < 3; k++) begin
            req(1, 1'b1, ALU_ADD, k, 100);
            tick();
            chk("bp_grant", seen_g, 2'b10);
            chk("bp_r0_hold", r0_result, 32'd3);
            chk("bp_r1_result", r1_result, 32'(k + 100));
        end
        rr = 2'b11;
        tick();
        chk("bp_release", seen_g[0], 1'b1);
        chk("bp_new_r0", r0_result, 32'd8);
        v = '0;
        tick();

        // Compare flag on r1.
        req(1, 1'b1, ALU_COMPARE_E_ZERO, 9, 9);
        tick();
        chk("cmp_eq_zero", r1_zero, 1'b1);
        chk("cmp_eq_result", r1_result, '0);
        req(1, 1'b1, ALU_COMPARE_E_ZERO, 9, 8);
        tick();
        chk("cmp_ne_zero", r1_zero, 1'b0);
        chk("cmp_ne_result", r1_result, '0);
        v = '0;
        tick();

        // Reset asserted at the edge where r0 would fire.
        req(0, 1'b1, ALU_ADD, 1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v = '0;
        chk("rst_r0_rvalid", r0_rvalid, 1'b0);
        chk("rst_r0_result", r0_result, '0);
        req(0, 1'b1, ALU_AND, 32'hFF, 32'h0F);
        req(1, 1'b1, ALU_OR, 32'h10, 32'h01);
        tick();
        chk("rst_first_grant", seen_g, 2'b01);
        v = '0;
        tick();

        // Streaming on r0.
        for (int k = 1; k <= 4; k++) begin
            req(0, 1'b1, ALU_ADD, k, 1);
            tick();
            chk("stream_rvalid", r0_rvalid, 1'b1);
            chk("stream_result", r0_result, 32'(k + 1));
        end
        v = '0;
        tick();

        // Randomized traffic; a waiting request keeps its payload stable.
        hold = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    c[i] = CW'($urandom_range(0, 5) == 5 ? 10 : $urandom_range(0, 4));
                    a[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
                    b[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
                end
                rr[i] = ($urandom_range(0, 2) != 0);
            end
            tick();
            hold[0] = v[0] && !seen_g[0] && !rst;
            hold[1] = v[1] && !seen_g[1] && !rst;
        end

        // Drain all outstanding responses.
        rst = 1'b0; v = '0; rr = 2'b11;
        tick();
        tick();
        tick();
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
